// File: rtl/reg_xfer_pkg.sv
// Shared definitions for the register-transfer controller: FSM encoding and
// transfer-counter sizing.
package reg_xfer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } xfer_state_t;

    localparam int                  XFER_CNT_W   = 16;
    localparam logic [XFER_CNT_W-1:0] XFER_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/reg_xfer_ctrl_idx_to_onehot.sv
// Index-to-one-hot decoder used for the register read and write strobes.
// Output is all-zero when the enable is low.
module idx_to_onehot #(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic [IDX_W-1:0]    i_idx,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot
);

    // Decode one bit per register position.
    always_comb begin
        o_onehot = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            o_onehot[k] = i_en && (i_idx == k[IDX_W-1:0]);
        end
    end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Register-transfer sequencer: READ/WRITE strobes for the shared data bus.
// Optional completed-transfer counter enabled by the REG_XFER_CNT_EN macro.
module reg_xfer_ctrl
    import reg_xfer_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 4,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_imm_sel,
    input  logic [IDX_W-1:0]      req_src,
    input  logic [IDX_W-1:0]      req_dst,
    input  logic [DATA_W-1:0]     req_imm,
    output logic [NUM_REGS-1:0]   rd_en,
    output logic [NUM_REGS-1:0]   wr_en,
    output logic                  bus_drv_en,
    output logic [DATA_W-1:0]     bus_drv_data,
    output logic                  busy,
    output logic                  done,
    output logic [XFER_CNT_W-1:0] xfer_cnt
);

    xfer_state_t         r_state;
    logic [IDX_W-1:0]    r_dst;
    logic                r_req_ready;
    logic [NUM_REGS-1:0] r_rd_en;
    logic [NUM_REGS-1:0] r_wr_en;
    logic                r_bus_drv_en;
    logic [DATA_W-1:0]   r_bus_drv_data;
    logic                r_busy;
    logic                r_done;
    logic [NUM_REGS-1:0] w_rd_onehot;
    logic [NUM_REGS-1:0] w_wr_onehot;
    logic                w_accept;

    assign w_accept = req_valid && r_req_ready;

    // A move reads the source register; an immediate leaves all reads off.
    idx_to_onehot #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_rd_dec (
        .i_idx    (req_src),
        .i_en     (!req_imm_sel),
        .o_onehot (w_rd_onehot)
    );

    idx_to_onehot #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_wr_dec (
        .i_idx    (r_dst),
        .i_en     (1'b1),
        .o_onehot (w_wr_onehot)
    );

    // Transfer FSM; the read strobe / bus driver register doubles as the latched source.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_dst          <= '0;
            r_req_ready    <= 1'b1;
            r_rd_en        <= '0;
            r_wr_en        <= '0;
            r_bus_drv_en   <= 1'b0;
            r_bus_drv_data <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done  <= 1'b0;
                    r_wr_en <= '0;
                    if (w_accept) begin
                        r_state        <= ST_READ;
                        r_dst          <= req_dst;
                        r_req_ready    <= 1'b0;
                        r_busy         <= 1'b1;
                        r_rd_en        <= w_rd_onehot;
                        r_bus_drv_en   <= req_imm_sel;
                        r_bus_drv_data <= req_imm_sel ? req_imm : '0;
                    end else begin
                        r_state        <= ST_IDLE;
                        r_req_ready    <= 1'b1;
                        r_busy         <= 1'b0;
                        r_rd_en        <= '0;
                        r_bus_drv_en   <= 1'b0;
                        r_bus_drv_data <= '0;
                    end
                end
                ST_READ: begin
                    r_state <= ST_WRITE;
                    r_wr_en <= w_wr_onehot;
                end
                ST_WRITE: begin
                    r_state        <= ST_IDLE;
                    r_rd_en        <= '0;
                    r_wr_en        <= '0;
                    r_bus_drv_en   <= 1'b0;
                    r_bus_drv_data <= '0;
                    r_busy         <= 1'b0;
                    r_req_ready    <= 1'b1;
                    r_done         <= 1'b1;
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_rd_en        <= '0;
                    r_wr_en        <= '0;
                    r_bus_drv_en   <= 1'b0;
                    r_bus_drv_data <= '0;
                    r_busy         <= 1'b0;
                    r_req_ready    <= 1'b1;
                    r_done         <= 1'b0;
                end
            endcase
        end
    end

`ifdef REG_XFER_CNT_EN
    logic [XFER_CNT_W-1:0] r_xfer_cnt;

    // Saturating count of retired transfers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (r_done && (r_xfer_cnt != XFER_CNT_MAX)) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end else begin
            r_xfer_cnt <= r_xfer_cnt;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`else
    assign xfer_cnt = 16'h0000;
`endif

    assign req_ready    = r_req_ready;
    assign rd_en        = r_rd_en;
    assign wr_en        = r_wr_en;
    assign bus_drv_en   = r_bus_drv_en;
    assign bus_drv_data = r_bus_drv_data;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Self-checking bench for reg_xfer_ctrl: directed timing checks plus a
// scoreboard matched against every write strobe.
module tb_reg_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_imm_sel = 1'b0;
    logic [1:0]  req_src = 2'd0;
    logic [1:0]  req_dst = 2'd0;
    logic [7:0]  req_imm = 8'd0;
    logic [3:0]  rd_en;
    logic [3:0]  wr_en;
    logic        bus_drv_en;
    logic [7:0]  bus_drv_data;
    logic        busy;
    logic        done;
    logic [15:0] xfer_cnt;

    reg_xfer_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_imm_sel  (req_imm_sel),
        .req_src      (req_src),
        .req_dst      (req_dst),
        .req_imm      (req_imm),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .bus_drv_en   (bus_drv_en),
        .bus_drv_data (bus_drv_data),
        .busy         (busy),
        .done         (done),
        .xfer_cnt     (xfer_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       imm;
        logic [1:0] src;
        logic [1:0] dst;
        logic [7:0] val;
    } xfer_t;

    xfer_t sb[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    wr_pulses = 0;
    int    done_pulses = 0;
    logic  prev_wr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        logic [3:0] one;
        one = 4'b0001;
        return one << idx;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle monitor: bus invariant, done timing, scoreboard on write strobes.
    always @(negedge clk) begin
        xfer_t e;
        chk("inv_bus", 32'(($countones(rd_en) + 32'(bus_drv_en)) <= 1), 32'd1);
        chk("inv_wr", 32'($countones(wr_en) <= 1), 32'd1);
        chk("done_timing", 32'(done), 32'(prev_wr));
        if (done) done_pulses++;
        if (wr_en != 4'b0000) begin
            wr_pulses++;
            if (sb.size() == 0) begin
                chk("sb_unexpected_wr", 32'(wr_en), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_wr_en", 32'(wr_en), 32'(onehot(e.dst)));
                chk("sb_bus_en", 32'(bus_drv_en), 32'(e.imm));
                chk("sb_bus_data", 32'(bus_drv_data), e.imm ? 32'(e.val) : 32'd0);
                chk("sb_rd_en", 32'(rd_en), e.imm ? 32'd0 : 32'(onehot(e.src)));
            end
        end
        prev_wr = (rd_en !== 4'bxxxx) && (wr_en != 4'b0000) && rst_n;
    end

    // Drive a request from a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic imm, input logic [1:0] src, input logic [1:0] dst,
                        input logic [7:0] val, input logic keep, output int acc_cyc);
        xfer_t e;
        int n;
        n = 0;
        req_valid = 1'b1;
        req_imm_sel = imm;
        req_src = src;
        req_dst = dst;
        req_imm = val;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc_cyc = cyc;
        if (n >= 20) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            e.imm = imm; e.src = src; e.dst = dst; e.val = val;
            sb.push_back(e);
        end
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int a0, a1, a2, wr0, dn0, n;

        // Reset held with a pending request.
        req_valid = 1'b1;
        req_src = 2'd2;
        req_dst = 2'd1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_bus_en", 32'(bus_drv_en), 32'd0);
        chk("rst_bus_data", 32'(bus_drv_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt", 32'(xfer_cnt), 32'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        idle(2);

        // Move src=1 -> dst=3.
        send(1'b0, 2'd1, 2'd3, 8'h00, 1'b0, a0);
        chk("mv_t1_rd", 32'(rd_en), 32'h2);
        chk("mv_t1_wr", 32'(wr_en), 32'h0);
        chk("mv_t1_busy", 32'(busy), 32'd1);
        chk("mv_t1_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("mv_t2_rd", 32'(rd_en), 32'h2);
        chk("mv_t2_wr", 32'(wr_en), 32'h8);
        @(negedge clk);
        chk("mv_t3_done", 32'(done), 32'd1);
        chk("mv_t3_ready", 32'(req_ready), 32'd1);
        chk("mv_t3_busy", 32'(busy), 32'd0);
        chk("mv_t3_rd", 32'(rd_en), 32'h0);
        idle(2);

        // Immediate A5 -> dst=2.
        send(1'b1, 2'd0, 2'd2, 8'hA5, 1'b0, a0);
        chk("im_t1_en", 32'(bus_drv_en), 32'd1);
        chk("im_t1_data", 32'(bus_drv_data), 32'hA5);
        chk("im_t1_rd", 32'(rd_en), 32'h0);
        chk("im_t1_wr", 32'(wr_en), 32'h0);
        @(negedge clk);
        chk("im_t2_en", 32'(bus_drv_en), 32'd1);
        chk("im_t2_data", 32'(bus_drv_data), 32'hA5);
        chk("im_t2_rd", 32'(rd_en), 32'h0);
        chk("im_t2_wr", 32'(wr_en), 32'h4);
        @(negedge clk);
        chk("im_t3_data", 32'(bus_drv_data), 32'h0);
        chk("im_t3_en", 32'(bus_drv_en), 32'd0);
        chk("im_t3_done", 32'(done), 32'd1);
        idle(1);

        // Back-to-back with req_valid held high, including src==dst.
        dn0 = done_pulses;
        send(1'b0, 2'd2, 2'd0, 8'h00, 1'b1, a0);
        send(1'b1, 2'd3, 2'd1, 8'h3C, 1'b1, a1);
        send(1'b0, 2'd3, 2'd3, 8'h00, 1'b0, a2);
        chk("b2b_gap1", 32'(a1 - a0), 32'd3);
        chk("b2b_gap2", 32'(a2 - a1), 32'd3);
        idle(4);
        chk("b2b_done_cnt", 32'(done_pulses - dn0), 32'd3);
        chk("b2b_sb_empty", 32'(sb.size()), 32'd0);

`ifdef REG_XFER_CNT_EN
        chk("cnt_five", 32'(xfer_cnt), 32'd5);
        force dut.r_xfer_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.r_xfer_cnt;
        @(negedge clk);
        send(1'b1, 2'd0, 2'd1, 8'h5A, 1'b0, a0);
        idle(4);
        chk("cnt_sat", 32'(xfer_cnt), 32'hFFFF);
`else
        chk("cnt_off", 32'(xfer_cnt), 32'd0);
        send(1'b1, 2'd0, 2'd1, 8'h5A, 1'b0, a0);
        idle(4);
        chk("cnt_off2", 32'(xfer_cnt), 32'd0);
`endif

        // Reset during READ abandons the transfer.
        send(1'b0, 2'd0, 2'd1, 8'h00, 1'b0, a0);
        wr0 = wr_pulses;
        dn0 = done_pulses;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_ready", 32'(req_ready), 32'd1);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_rd", 32'(rd_en), 32'h0);
        chk("mr_wr", 32'(wr_en), 32'h0);
        chk("mr_cnt", 32'(xfer_cnt), 32'd0);
        rst_n = 1'b1;
        sb.delete();
        idle(5);
        chk("mr_no_wr", 32'(wr_pulses - wr0), 32'd0);
        chk("mr_no_done", 32'(done_pulses - dn0), 32'd0);

        // Recovery transfer after the abandoned one.
        send(1'b0, 2'd3, 2'd0, 8'h00, 1'b0, a0);
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("final_sb_drain", 32'(sb.size()), 32'd0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
